// File: rtl/usb_uart_pkg.sv
// Shared types and width helpers for the USB UART byte bridge.
package usb_uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int count_w(input int word_bytes);
        return $clog2(word_bytes + 1);
    endfunction

endpackage

// File: rtl/usb_uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered occupancy count.
module usb_uart_sync_fifo
    import usb_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    output logic                      full_o,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [LW-1:0]    cnt_q;
    logic [LW-1:0]    cnt_d;
    logic             do_push;
    logic             do_pop;

    // Full comes from the registered count, so a pop never frees space for a same-cycle push.
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];
    assign level_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + LW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/usb_uart_fifo_bridge.sv
// Word <-> byte bridge to the USB UART core pipelines, with TX/RX FIFOs and RX idle flush.
// Optional host loopback is compiled in with USB_UART_LOOPBACK_EN.
module usb_uart_fifo_bridge
    import usb_uart_pkg::*;
#(
    parameter int WORD_BYTES = 1,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int IDLE_FLUSH = 4800
) (
    input  logic                            clk_48mhz,
    input  logic                            reset_n,
`ifdef USB_UART_LOOPBACK_EN
    input  logic                            loopback,
`endif
    input  logic [WORD_BYTES*8-1:0]         tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [level_w(TX_DEPTH)-1:0]    tx_level,
    output logic [WORD_BYTES*8-1:0]         rx_data,
    output logic [count_w(WORD_BYTES)-1:0]  rx_bytes,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [level_w(RX_DEPTH)-1:0]    rx_level,
    output logic [7:0]                      core_in_data,
    output logic                            core_in_valid,
    input  logic                            core_in_ready,
    input  logic [7:0]                      core_out_data,
    input  logic                            core_out_valid,
    output logic                            core_out_ready
);

    localparam int       WORD_W     = WORD_BYTES * BYTE_W;
    localparam int       CW         = count_w(WORD_BYTES);
    localparam int       RXW        = WORD_W + CW;
    localparam int       TW         = $clog2(IDLE_FLUSH + 2);
    localparam bit       FLUSH_EN   = (IDLE_FLUSH != 0) && (WORD_BYTES > 1);
    localparam int       FLUSH_LAST = (IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0;
    localparam [CW-1:0]  LAST_IDX   = CW'(WORD_BYTES - 1);

    logic loop_act;

    logic              tx_full, tx_empty, tx_pop;
    logic [WORD_W-1:0] tx_head;
    ser_state_t        ser_state_q;
    logic [WORD_W-1:0] ser_shift_q;
    logic [CW-1:0]     ser_idx_q;
    logic              ser_valid_q, avail_q, ser_ready, ser_last;

    logic [WORD_W-1:0] asm_word_q, asm_word_d;
    logic [CW-1:0]     asm_idx_q;
    logic [TW-1:0]     timer_q;
    logic              asm_last, flush_hit, asm_ready, byte_acc, full_push, flush_push;
    logic              rx_full, rx_empty;
    logic [RXW-1:0]    rx_push_data, rx_head;

    assign tx_ready = !tx_full && !loop_act;

    usb_uart_sync_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i       (clk_48mhz),
        .rst_ni      (reset_n),
        .push_i      (tx_valid && tx_ready),
        .push_data_i (tx_data),
        .full_o      (tx_full),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .level_o     (tx_level)
    );

    assign ser_ready = core_in_ready && !loop_act;
    assign ser_last  = (ser_idx_q == LAST_IDX);

    // avail_q adds one registered stage before an idle load; back-to-back reloads bypass it.
    always_comb begin
        tx_pop = 1'b0;
        if (!loop_act && !tx_empty) begin
            if (ser_state_q == S_IDLE) tx_pop = avail_q;
            else                       tx_pop = ser_ready && ser_last;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            ser_state_q <= S_IDLE;
            ser_shift_q <= '0;
            ser_idx_q   <= '0;
            ser_valid_q <= 1'b0;
            avail_q     <= 1'b0;
        end else begin
            avail_q <= !tx_empty;
            if (tx_pop) begin
                ser_shift_q <= tx_head;
                ser_idx_q   <= '0;
                ser_valid_q <= 1'b1;
                ser_state_q <= S_SEND;
            end else if (ser_state_q == S_SEND && ser_ready) begin
                if (ser_last) begin
                    ser_valid_q <= 1'b0;
                    ser_state_q <= S_IDLE;
                end else begin
                    ser_shift_q <= ser_shift_q >> BYTE_W;
                    ser_idx_q   <= ser_idx_q + CW'(1);
                end
            end
        end
    end

    assign core_in_data  = loop_act ? core_out_data  : ser_shift_q[BYTE_W-1:0];
    assign core_in_valid = loop_act ? core_out_valid : ser_valid_q;

    assign asm_last   = (asm_idx_q == LAST_IDX);
    assign flush_hit  = FLUSH_EN && (asm_idx_q != '0) && (timer_q == TW'(FLUSH_LAST));
    assign asm_ready  = !(asm_last && rx_full) && !(flush_hit && rx_full);
    assign byte_acc   = !loop_act && core_out_valid && asm_ready;
    assign full_push  = byte_acc && asm_last;
    assign flush_push = flush_hit && !byte_acc && !rx_full;

    always_comb begin
        asm_word_d = asm_word_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (asm_idx_q == CW'(k)) asm_word_d[k*BYTE_W +: BYTE_W] = core_out_data;
        end
    end

    // Upper bytes of asm_word_q stay zero, so a flushed partial word is already padded.
    assign rx_push_data = full_push ? {CW'(WORD_BYTES), asm_word_d} : {asm_idx_q, asm_word_q};

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            asm_word_q <= '0;
            asm_idx_q  <= '0;
            timer_q    <= '0;
        end else if (byte_acc) begin
            timer_q <= '0;
            if (asm_last) begin
                asm_word_q <= '0;
                asm_idx_q  <= '0;
            end else begin
                asm_word_q <= asm_word_d;
                asm_idx_q  <= asm_idx_q + CW'(1);
            end
        end else if (flush_push) begin
            asm_word_q <= '0;
            asm_idx_q  <= '0;
            timer_q    <= '0;
        end else if (FLUSH_EN && asm_idx_q != '0 && !flush_hit) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    usb_uart_sync_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i       (clk_48mhz),
        .rst_ni      (reset_n),
        .push_i      (full_push || flush_push),
        .push_data_i (rx_push_data),
        .full_o      (rx_full),
        .pop_i       (rx_ready),
        .head_o      (rx_head),
        .empty_o     (rx_empty),
        .level_o     (rx_level)
    );

    assign rx_valid       = !rx_empty;
    assign rx_data        = rx_head[WORD_W-1:0];
    assign rx_bytes       = rx_head[RXW-1:WORD_W];
    assign core_out_ready = loop_act ? core_in_ready : asm_ready;

`ifdef USB_UART_LOOPBACK_EN
    logic loop_q;

    // Mode only changes between words, never with a byte half-serialised or half-assembled.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            loop_q <= 1'b0;
        end else if (ser_state_q == S_IDLE && asm_idx_q == '0) begin
            loop_q <= loopback;
        end
    end
    assign loop_act = loop_q;
`else
    assign loop_act = 1'b0;
`endif

endmodule

// File: tb/tb_usb_uart_fifo_bridge.sv
// Directed scoreboard bench for usb_uart_fifo_bridge (WORD_BYTES=4, depths 4/2, IDLE_FLUSH=10).
module tb_usb_uart_fifo_bridge;

    logic        clk_48mhz;
    logic        reset_n;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_level;
    logic [31:0] rx_data;
    logic [2:0]  rx_bytes;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  rx_level;
    logic [7:0]  core_in_data;
    logic        core_in_valid;
    logic        core_in_ready;
    logic [7:0]  core_out_data;
    logic        core_out_valid;
    logic        core_out_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_tx_q[$];
    logic [34:0] exp_rx_q[$];

    usb_uart_fifo_bridge #(
        .WORD_BYTES (4),
        .TX_DEPTH   (4),
        .RX_DEPTH   (2),
        .IDLE_FLUSH (10)
    ) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_level       (tx_level),
        .rx_data        (rx_data),
        .rx_bytes       (rx_bytes),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_level       (rx_level),
        .core_in_data   (core_in_data),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_out_data  (core_out_data),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready)
    );

    // clock / watchdog
    initial clk_48mhz = 1'b0;
    always #5 clk_48mhz = ~clk_48mhz;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitors: a transfer seen at a negedge completes on the next posedge
    always @(negedge clk_48mhz) begin
        if (reset_n && core_in_valid && core_in_ready) begin
            if (exp_tx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected got=%h exp=none @%0t", core_in_data, $time);
            end else begin
                check("tx_byte", {56'd0, core_in_data}, {56'd0, exp_tx_q.pop_front()});
            end
        end
    end

    always @(negedge clk_48mhz) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_rx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected got=%h exp=none @%0t", {rx_bytes, rx_data}, $time);
            end else begin
                check("rx_word", {29'd0, rx_bytes, rx_data}, {29'd0, exp_rx_q.pop_front()});
            end
        end
    end

    // drivers: called at posedge+1, return at posedge+1 after the accepting edge
    task automatic try_push(input logic [31:0] w, input int max_cyc, output bit ok);
        ok       = 1'b0;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk_48mhz);
            if (tx_ready) ok = 1'b1;
            @(posedge clk_48mhz);
            #1;
        end
        if (ok) begin
            tx_valid = 1'b0;
            for (int b = 0; b < 4; b++) exp_tx_q.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_cyc, output bit ok);
        ok             = 1'b0;
        core_out_data  = b;
        core_out_valid = 1'b1;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk_48mhz);
            if (core_out_ready) ok = 1'b1;
            @(posedge clk_48mhz);
            #1;
        end
        if (ok) core_out_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        for (int b = 0; b < 4; b++) begin
            send_byte(w[b*8 +: 8], 20, ok);
            check("rx_byte_accept", {63'd0, ok}, 64'd1);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_48mhz);
            #1;
        end
    endtask

    initial begin
        bit ok;
        bit got;
        int n;
        logic [31:0] w;

        reset_n        = 1'b1;
        tx_data        = '0;
        tx_valid       = 1'b0;
        rx_ready       = 1'b1;
        core_in_ready  = 1'b1;
        core_out_data  = '0;
        core_out_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
        check("rst_core_out_ready", {63'd0, core_out_ready}, 64'd1);
        check("rst_core_in_valid", {63'd0, core_in_valid}, 64'd0);
        check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("rst_levels", {59'd0, tx_level, rx_level}, 64'd0);
        check("rst_rx_data", {29'd0, rx_bytes, rx_data}, 64'd0);
        @(posedge clk_48mhz);
        @(posedge clk_48mhz);
        #1 reset_n = 1'b1;
        cycles(2);

        // TX latency and byte order
        try_push(32'hDEADBEEF, 5, ok);
        check("t1_push_ok", {63'd0, ok}, 64'd1);
        check("t1_valid_n0", {63'd0, core_in_valid}, 64'd0);
        cycles(1);
        check("t1_valid_n1", {63'd0, core_in_valid}, 64'd0);
        check("t1_level_n1", {61'd0, tx_level}, 64'd1);
        cycles(1);
        check("t1_valid_n2", {63'd0, core_in_valid}, 64'd1);
        check("t1_byte0", {56'd0, core_in_data}, 64'hEF);
        check("t1_level_n2", {61'd0, tx_level}, 64'd0);
        cycles(6);
        check("t1_idle_valid", {63'd0, core_in_valid}, 64'd0);

        // TX backpressure: one word in the serialiser, four in the FIFO, sixth held off
        core_in_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 32'h10203040 + 32'h01010101 * i;
            try_push(w, 4, ok);
            check("t2_push_ok", {63'd0, ok}, 64'd1);
        end
        check("t2_level_full", {61'd0, tx_level}, 64'd4);
        check("t2_ready_low", {63'd0, tx_ready}, 64'd0);
        try_push(32'hA5A5_5A5A, 3, ok);
        check("t2_refused", {63'd0, ok}, 64'd0);
        check("t2_level_hold", {61'd0, tx_level}, 64'd4);
        core_in_ready = 1'b1;
        try_push(32'hA5A5_5A5A, 40, ok);
        check("t2_late_push_ok", {63'd0, ok}, 64'd1);
        cycles(40);
        check("t2_drained_level", {61'd0, tx_level}, 64'd0);
        check("t2_drained_q", 64'(exp_tx_q.size()), 64'd0);

        // RX full word
        exp_rx_q.push_back({3'd4, 32'h44332211});
        send_word(32'h44332211);
        cycles(3);
        check("t3_level", {62'd0, rx_level}, 64'd0);

        // RX idle flush of a partial word
        exp_rx_q.push_back({3'd2, 32'h0000BBAA});
        send_byte(8'hAA, 5, ok);
        send_byte(8'hBB, 5, ok);
        check("t4_bytes_ok", {63'd0, ok}, 64'd1);
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk_48mhz);
            n++;
            @(negedge clk_48mhz);
            if (rx_valid) got = 1'b1;
        end
        check("t4_flushed", {63'd0, got}, 64'd1);
        check("t4_flush_delay", 64'(n), 64'd10);
        cycles(3);

        // RX backpressure with RX_DEPTH=2
        rx_ready = 1'b0;
        exp_rx_q.push_back({3'd4, 32'h04030201});
        exp_rx_q.push_back({3'd4, 32'h40302010});
        exp_rx_q.push_back({3'd4, 32'hC3C2C1C0});
        send_word(32'h04030201);
        send_word(32'h40302010);
        send_byte(8'hC0, 5, ok);
        send_byte(8'hC1, 5, ok);
        send_byte(8'hC2, 5, ok);
        check("t5_c2_ok", {63'd0, ok}, 64'd1);
        send_byte(8'hC3, 3, ok);
        check("t5_c3_blocked", {63'd0, ok}, 64'd0);
        check("t5_ready_low", {63'd0, core_out_ready}, 64'd0);
        check("t5_level_full", {62'd0, rx_level}, 64'd2);
        rx_ready = 1'b1;
        @(posedge clk_48mhz);
        #1 rx_ready = 1'b0;
        send_byte(8'hC3, 5, ok);
        check("t5_c3_accepted", {63'd0, ok}, 64'd1);
        check("t5_level_after", {62'd0, rx_level}, 64'd2);
        rx_ready = 1'b1;
        cycles(5);
        check("t5_level_drained", {62'd0, rx_level}, 64'd0);

        // reset mid-word: TX idx=1, RX idx=2, one word queued in RX
        core_in_ready = 1'b0;
        rx_ready      = 1'b0;
        send_word(32'h99999999);
        try_push(32'hCAFEF00D, 4, ok);
        check("t6_push_ok", {63'd0, ok}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_48mhz);
            if (core_in_valid) got = 1'b1;
        end
        check("t6_tx_valid_seen", {63'd0, got}, 64'd1);
        @(posedge clk_48mhz);
        #1 core_in_ready = 1'b1;
        @(posedge clk_48mhz);
        #1 core_in_ready = 1'b0;
        send_byte(8'h5A, 5, ok);
        send_byte(8'h5B, 5, ok);
        check("t6_rx_partial_ok", {63'd0, ok}, 64'd1);
        check("t6_pre_rx_valid", {63'd0, rx_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_core_in_valid", {63'd0, core_in_valid}, 64'd0);
        check("t6_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("t6_levels", {59'd0, tx_level, rx_level}, 64'd0);
        check("t6_rx_bytes", {61'd0, rx_bytes}, 64'd0);
        check("t6_tx_ready", {63'd0, tx_ready}, 64'd1);
        exp_tx_q.delete();
        @(posedge clk_48mhz);
        @(posedge clk_48mhz);
        #1 reset_n = 1'b1;
        cycles(1);
        core_in_ready = 1'b1;
        rx_ready      = 1'b1;
        try_push(32'h01020304, 5, ok);
        check("t6_post_push_ok", {63'd0, ok}, 64'd1);
        exp_rx_q.push_back({3'd4, 32'h88776655});
        send_word(32'h88776655);
        cycles(20);

        check("end_tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
        check("end_rx_q_empty", 64'(exp_rx_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
